// File: rtl/snoop_loader_pkg.sv
// Shared definitions for the snoop loader: command codes, FSM state encoding
// and datapath widths used by the loader and its read sequencer.
// Ports: none (package only).
package snoop_loader_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 8;
   // One extra bit so that a count byte of zero can stand for 256 bytes
   localparam int CNT_W  = 9;

   localparam logic [DATA_W-1:0] CMD_WRITE = 8'h01;
   localparam logic [DATA_W-1:0] CMD_RUN   = 8'h02;
   localparam logic [DATA_W-1:0] CMD_HALT  = 8'h03;
   localparam logic [DATA_W-1:0] CMD_READ  = 8'h04;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_W_ADDR,
      ST_W_CNT,
      ST_W_DATA,
      ST_R_ADDR,
      ST_R_WAIT,
      ST_R_OUT
   } state_e;

   // A count byte of 0 means a full 256-byte burst
   function automatic logic [CNT_W-1:0] countFromByte(input logic [DATA_W-1:0] b);
      return (b == '0) ? CNT_W'(256) : {1'b0, b};
   endfunction

endpackage

// File: rtl/snoop_loader_rd.sv
// Read sequencer for the snoop loader. On start_i it waits RD_LATENCY clocks
// for discus to present snoopq, captures it into the output register and
// holds it valid until the consumer accepts it.
// Ports:
//   clk_i, reset_ni    clock, asynchronous active-low reset
//   start_i            pulse: snoopa now holds the read address
//   snoopq_i           discus read data
//   out_ready_i        consumer ready
//   capture_o          high on the cycle snoopq_i is captured
//   done_o             high on the cycle the readback byte is handed off
//   out_data_o/valid_o readback byte and its valid flag
// Only instantiated when SNOOP_LOADER_READBACK_EN is defined.
module snoop_loader_rd
   import snoop_loader_pkg::*;
#(
   parameter int unsigned RD_LATENCY = 2
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              start_i,
   input  logic [DATA_W-1:0] snoopq_i,
   input  logic              out_ready_i,
   output logic              capture_o,
   output logic              done_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic              out_valid_o
);

   localparam int WAIT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   // The capture edge itself is the last of the RD_LATENCY clocks, so the
   // counter starts one short. RD_LATENCY must be at least 1.
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(RD_LATENCY - 1);

   logic              waiting_q;
   logic [WAIT_W-1:0] waitCnt_q;
   logic [DATA_W-1:0] outData_q;
   logic              outValid_q;

   assign capture_o   = waiting_q && (waitCnt_q == '0);
   assign done_o      = outValid_q && out_ready_i;
   assign out_data_o  = outData_q;
   assign out_valid_o = outValid_q;

   // Wait counter and output register; the byte stays valid until handed off
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         waiting_q  <= 1'b0;
         waitCnt_q  <= '0;
         outData_q  <= '0;
         outValid_q <= 1'b0;
      end else begin
         if (start_i) begin
            waiting_q <= 1'b1;
            waitCnt_q <= WAIT_INIT;
         end else if (capture_o) begin
            waiting_q  <= 1'b0;
            outData_q  <= snoopq_i;
            outValid_q <= 1'b1;
         end else if (waiting_q) begin
            waitCnt_q <= waitCnt_q - WAIT_W'(1);
         end
         if (done_o) begin
            outValid_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/snoop_loader.sv
// Upstream feeder for the discus snoop port. Parses a valid/ready byte stream
// of framed commands (WRITE addr cnt data..., RUN, HALT, READ addr) into
// snoop-port program writes and owns the core's program-mode and reset lines.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   in_data/in_valid/in_ready  command byte stream
//   snoopa/snoopd/snoopp       program address, data and program mode to discus
//   snoopm                     snoop read strobe (readback builds only)
//   snoopq                     discus read data
//   cpu_reset                  active-high reset to discus
//   err                        sticky unknown-command flag
//   out_data/out_valid/out_ready readback stream
// Optional feature: define SNOOP_LOADER_READBACK_EN to enable the READ command;
// otherwise 0x04 is an unknown command and the readback outputs are tied low.
module snoop_loader
   import snoop_loader_pkg::*;
#(
   parameter bit          BOOT_HALTED = 1'b1,
   parameter int unsigned RD_LATENCY  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] snoopa,
   output logic [DATA_W-1:0] snoopd,
   output logic              snoopp,
   output logic              snoopm,
   input  logic [DATA_W-1:0] snoopq,
   output logic              cpu_reset,
   output logic              err,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]  remain_q, remain_d;
   logic [ADDR_W-1:0] snoopA_q, snoopA_d;
   logic [DATA_W-1:0] snoopD_q, snoopD_d;
   logic              snoopP_q, snoopP_d;
   logic              cpuReset_q, cpuReset_d;
   logic              err_q, err_d;
   logic              accept;

   assign accept    = in_valid && in_ready;
   assign snoopa    = snoopA_q;
   assign snoopd    = snoopD_q;
   assign snoopp    = snoopP_q;
   assign cpu_reset = cpuReset_q;
   assign err       = err_q;

`ifdef SNOOP_LOADER_READBACK_EN
   logic rdStart;
   logic rdCapture;
   logic rdDone;
   logic snoopM_q;

   assign rdStart = accept && (state_q == ST_R_ADDR);
   assign snoopm  = snoopM_q;

   snoop_loader_rd #(
      .RD_LATENCY (RD_LATENCY)
   ) u_rd (
      .clk_i       (clk),
      .reset_ni    (reset),
      .start_i     (rdStart),
      .snoopq_i    (snoopq),
      .out_ready_i (out_ready),
      .capture_o   (rdCapture),
      .done_o      (rdDone),
      .out_data_o  (out_data),
      .out_valid_o (out_valid)
   );

   // Read strobe spans the whole read, from address accept until hand-off
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         snoopM_q <= 1'b0;
      end else if (rdStart) begin
         snoopM_q <= 1'b1;
      end else if (rdDone) begin
         snoopM_q <= 1'b0;
      end
   end
`else
   logic unusedRd;

   assign unusedRd  = ^{snoopq, out_ready, (RD_LATENCY > 0)};
   assign snoopm    = 1'b0;
   assign out_data  = '0;
   assign out_valid = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: frames advance one accepted byte at a time
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (in_data)
                  CMD_WRITE: state_d = ST_W_ADDR;
`ifdef SNOOP_LOADER_READBACK_EN
                  CMD_READ:  state_d = ST_R_ADDR;
`endif
                  default:   state_d = ST_IDLE;
               endcase
            end
         end
         ST_W_ADDR: if (accept) state_d = ST_W_CNT;
         ST_W_CNT:  if (accept) state_d = ST_W_DATA;
         ST_W_DATA: if (accept && (remain_q == CNT_W'(1))) state_d = ST_IDLE;
`ifdef SNOOP_LOADER_READBACK_EN
         ST_R_ADDR: if (accept) state_d = ST_R_WAIT;
         ST_R_WAIT: if (rdCapture) state_d = ST_R_OUT;
         ST_R_OUT:  if (rdDone) state_d = ST_IDLE;
`endif
         default:   state_d = ST_IDLE;
      endcase
   end

   // Output and datapath next-values; snoopa/snoopd hold between data bytes
   always_comb begin
      in_ready   = 1'b0;
      ptr_d      = ptr_q;
      remain_d   = remain_q;
      snoopA_d   = snoopA_q;
      snoopD_d   = snoopD_q;
      snoopP_d   = snoopP_q;
      cpuReset_d = cpuReset_q;
      err_d      = err_q;
      case (state_q)
         ST_IDLE, ST_W_ADDR, ST_W_CNT, ST_W_DATA, ST_R_ADDR: in_ready = 1'b1;
         default: in_ready = 1'b0;
      endcase
      if (accept) begin
         case (state_q)
            ST_IDLE: begin
               case (in_data)
                  CMD_WRITE, CMD_HALT: begin
                     snoopP_d   = 1'b1;
                     cpuReset_d = 1'b1;
                  end
                  CMD_RUN: begin
                     snoopP_d   = 1'b0;
                     cpuReset_d = 1'b0;
                  end
`ifdef SNOOP_LOADER_READBACK_EN
                  CMD_READ: ;
`endif
                  default: err_d = 1'b1;
               endcase
            end
            ST_W_ADDR: ptr_d = in_data;
            ST_W_CNT:  remain_d = countFromByte(in_data);
            ST_W_DATA: begin
               snoopA_d = ptr_q;
               snoopD_d = in_data;
               ptr_d    = ptr_q + ADDR_W'(1);
               remain_d = remain_q - CNT_W'(1);
            end
            ST_R_ADDR: snoopA_d = in_data;
            default: ;
         endcase
      end
   end

   // Datapath registers; program mode and core reset come up per BOOT_HALTED
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q      <= '0;
         remain_q   <= '0;
         snoopA_q   <= '0;
         snoopD_q   <= '0;
         snoopP_q   <= BOOT_HALTED;
         cpuReset_q <= BOOT_HALTED;
         err_q      <= 1'b0;
      end else begin
         ptr_q      <= ptr_d;
         remain_q   <= remain_d;
         snoopA_q   <= snoopA_d;
         snoopD_q   <= snoopD_d;
         snoopP_q   <= snoopP_d;
         cpuReset_q <= cpuReset_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_snoop_loader.sv
// Self-checking bench for snoop_loader. A frame-level reference model predicts
// the visible snoop-port state after every accepted byte; predictions are
// queued when a byte is issued and a monitor compares them on each handshake.
// Readback checks are compiled in when SNOOP_LOADER_READBACK_EN is defined.
module tb_snoop_loader;

   localparam bit          BOOT = 1'b1;
   localparam int unsigned RDL  = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] snoopa, snoopd, snoopq, out_data;
   logic       snoopp, snoopm, cpu_reset, err, out_valid, out_ready;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
      logic       p;
      logic       cr;
      logic       e;
      logic       m;
   } exp_t;

   exp_t       expQ[$];
   logic [7:0] readQ[$];
   logic [7:0] wrData[$];

   // Reference model of the visible snoop-port state
   logic [7:0] mA, mD;
   logic       mP, mCr, mE, mM;

   snoop_loader #(.BOOT_HALTED(BOOT), .RD_LATENCY(RDL)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .snoopa(snoopa), .snoopd(snoopd), .snoopp(snoopp),
      .snoopm(snoopm), .snoopq(snoopq), .cpu_reset(cpu_reset), .err(err),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic modelReset();
      mA = 8'h00; mD = 8'h00; mP = BOOT; mCr = BOOT; mE = 1'b0; mM = 1'b0;
   endtask

   task automatic pushExp();
      exp_t e;
      e.a = mA; e.d = mD; e.p = mP; e.cr = mCr; e.e = mE; e.m = mM;
      expQ.push_back(e);
   endtask

   // Presents one byte after a random stall and waits (bounded) for acceptance.
   // Called at posedge+2; returns at posedge+2 after the accepting edge.
   task automatic applyStimulus(input logic [7:0] b);
      bit got = 0;
      repeat ($urandom_range(0, 2)) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         @(posedge clk); #2;
      end
      in_data  = b;
      in_valid = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1;
            break;
         end
      end
      @(posedge clk); #2;
      in_valid = 1'b0;
      if (!got) checkOutput("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic checkReset();
      checkOutput("rst_snoopa", snoopa, 8'h00);
      checkOutput("rst_snoopd", snoopd, 8'h00);
      checkOutput("rst_snoopp", snoopp, BOOT);
      checkOutput("rst_cpu_reset", cpu_reset, BOOT);
      checkOutput("rst_err", err, 1'b0);
      checkOutput("rst_snoopm", snoopm, 1'b0);
      checkOutput("rst_out_valid", out_valid, 1'b0);
      checkOutput("rst_out_data", out_data, 8'h00);
      checkOutput("rst_in_ready", in_ready, 1'b1);
   endtask

   // WRITE frame using the bytes in wrData; count byte 0 means 256
   task automatic sendWrite(input logic [7:0] addr, input logic [7:0] cntByte);
      int n = (cntByte == 8'h00) ? 256 : int'(cntByte);
      mP = 1'b1; mCr = 1'b1;
      pushExp(); applyStimulus(8'h01);
      pushExp(); applyStimulus(addr);
      pushExp(); applyStimulus(cntByte);
      for (int i = 0; i < n; i++) begin
         mA = 8'(int'(addr) + i);
         mD = wrData[i];
         pushExp(); applyStimulus(wrData[i]);
      end
   endtask

   task automatic sendRun();
      mP = 1'b0; mCr = 1'b0;
      pushExp(); applyStimulus(8'h02);
   endtask

   task automatic sendHalt();
      mP = 1'b1; mCr = 1'b1;
      pushExp(); applyStimulus(8'h03);
   endtask

   task automatic sendUnknown(input logic [7:0] b);
      mE = 1'b1;
      pushExp(); applyStimulus(b);
   endtask

   task automatic waitDrain();
      for (int c = 0; c < 50 && expQ.size() != 0; c++) @(posedge clk);
      #2;
      checkOutput("queue_drained", expQ.size(), 0);
   endtask

`ifdef SNOOP_LOADER_READBACK_EN
   task automatic sendRead(input logic [7:0] addr, input logic [7:0] q);
      bit got = 0;
      snoopq = q;
      pushExp(); applyStimulus(8'h04);
      mA = addr; mM = 1'b1;
      pushExp(); applyStimulus(addr);
      readQ.push_back(q);
      mM = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (out_valid) begin
            got = 1;
            break;
         end
         @(posedge clk); #2;
      end
      if (!got) checkOutput("read_timeout", 32'd0, 32'd1);
      repeat ($urandom_range(0, 3)) begin
         @(posedge clk); #2;
      end
      out_ready = 1'b1;
      @(posedge clk); #2;
      out_ready = 1'b0;
   endtask
`endif

   // Monitor: every byte handshake pops one prediction; every readback
   // handshake pops one expected read byte
   initial begin : monitor
      exp_t       e;
      logic       hs, rdHs;
      logic [7:0] rdData;
      forever begin
         @(negedge clk);
         hs     = in_valid && in_ready && reset;
         rdHs   = out_valid && out_ready && reset;
         rdData = out_data;
         @(posedge clk); #1;
         if (hs) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_accept", 32'd1, 32'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("snoopa", snoopa, e.a);
               checkOutput("snoopd", snoopd, e.d);
               checkOutput("snoopp", snoopp, e.p);
               checkOutput("cpu_reset", cpu_reset, e.cr);
               checkOutput("err", err, e.e);
               checkOutput("snoopm", snoopm, e.m);
               checkOutput("out_valid_idle", out_valid, 1'b0);
            end
         end
         if (rdHs) begin
            if (readQ.size() == 0) checkOutput("unexpected_read", 32'd1, 32'd0);
            else checkOutput("out_data", rdData, readQ.pop_front());
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      logic [7:0] b;
      int         sel, n;
      reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; snoopq = 8'h00;
      modelReset();
      @(posedge clk); #2;
      checkReset();
      @(posedge clk); #2;
      reset = 1'b1;

      // Program load with the boot image
      wrData = '{8'h68, 8'h0C, 8'h34, 8'h03, 8'h4A, 8'h90, 8'h0C,
                 8'h38, 8'h42, 8'h4A, 8'h4A, 8'h42, 8'hA8};
      sendWrite(8'h00, 8'h0D);
      sendRun();
      sendRun();
      sendHalt();
      sendHalt();

      // Address wrap past 0xFF
      wrData = '{8'h11, 8'h22, 8'h33};
      sendWrite(8'hFE, 8'h03);

      // Full 256-byte burst, then a command must be parsed
      wrData.delete();
      for (int i = 0; i < 256; i++) wrData.push_back(8'($urandom));
      sendWrite(8'h10, 8'h00);
      checkOutput("burst_last_addr", snoopa, 8'h0F);
      sendRun();

      // Unknown command sets sticky err; following command still honoured
      sendUnknown(8'h7F);
      sendHalt();
      sendRun();
`ifndef SNOOP_LOADER_READBACK_EN
      sendUnknown(8'h04);
`endif

      // Reset in the middle of a data burst
      wrData = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      mP = 1'b1; mCr = 1'b1;
      pushExp(); applyStimulus(8'h01);
      pushExp(); applyStimulus(8'h40);
      pushExp(); applyStimulus(8'h05);
      mA = 8'h40; mD = 8'hAA; pushExp(); applyStimulus(8'hAA);
      mA = 8'h41; mD = 8'hBB; pushExp(); applyStimulus(8'hBB);
      waitDrain();
      reset = 1'b0;
      modelReset();
      @(negedge clk);
      checkReset();
      @(posedge clk); #2;
      reset = 1'b1;
      sendRun();

`ifdef SNOOP_LOADER_READBACK_EN
      // Directed readback: latency, hold while not ready, drop on hand-off
      begin
         int lat = 0;
         snoopq = 8'h5A;
         pushExp(); applyStimulus(8'h04);
         mA = 8'h20; mM = 1'b1;
         pushExp(); applyStimulus(8'h20);
         readQ.push_back(8'h5A);
         mM = 1'b0;
         checkOutput("rd_in_ready", in_ready, 1'b0);
         while (!out_valid && lat < 20) begin
            @(posedge clk); #2;
            lat++;
         end
         checkOutput("rd_latency", lat, RDL);
         repeat (3) begin
            @(posedge clk); #2;
            checkOutput("rd_hold_valid", out_valid, 1'b1);
            checkOutput("rd_hold_data", out_data, 8'h5A);
            checkOutput("rd_hold_in_ready", in_ready, 1'b0);
         end
         out_ready = 1'b1;
         @(posedge clk); #2;
         out_ready = 1'b0;
         checkOutput("rd_valid_drop", out_valid, 1'b0);
         checkOutput("rd_snoopm_drop", snoopm, 1'b0);
         checkOutput("rd_in_ready_back", in_ready, 1'b1);
      end
`endif

      // Randomized command frames
      for (int f = 0; f < 40; f++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1, 2, 3: begin
               n = $urandom_range(1, 6);
               wrData.delete();
               for (int i = 0; i < n; i++) wrData.push_back(8'($urandom));
               sendWrite(8'($urandom), 8'(n));
            end
            4: sendRun();
            5: sendHalt();
            6: begin
               b = 8'($urandom_range(5, 255));
               if ($urandom_range(0, 3) == 0) b = 8'h00;
               sendUnknown(b);
            end
`ifdef SNOOP_LOADER_READBACK_EN
            7: sendRead(8'($urandom), 8'($urandom));
`else
            7: sendUnknown(8'h04);
`endif
            default: sendRun();
         endcase
      end
      waitDrain();
      checkOutput("reads_drained", readQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
